// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin arbiter sharing one Wishbone B4 classic slave port between
// NUM_M masters. One master owns the slave at a time and keeps it for its whole CYC.
//
// Ports
//   clk, nrst              system clock, synchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i per-master Wishbone controls (one bit per master)
//   m_adr_i/m_dat_i/m_sel_i flattened per-master address/write data/byte select,
//                           master k at [k*W +: W]
//   m_ack_o/m_err_o        ACK/ERR routed to the current owner only
//   m_dat_o                slave read data, broadcast to all masters
//   s_*_o / s_*_i          shared slave port
//   grant_o                one-hot current owner, zero when idle
//
// Build option
//   WB_ARB_TIMEOUT_EN      adds an 8-bit watchdog. After TIMEOUT_CYC stalled strobe cycles it
//                          errors the owner and releases the bus. The owner cannot be granted
//                          again until it has dropped CYC.
module wb_rr_arbiter #(
  parameter int unsigned NUM_M       = 2,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [NUM_M-1:0]        m_cyc_i,
  input  logic [NUM_M-1:0]        m_stb_i,
  input  logic [NUM_M-1:0]        m_we_i,
  input  logic [NUM_M*AW-1:0]     m_adr_i,
  input  logic [NUM_M*DW-1:0]     m_dat_i,
  input  logic [NUM_M*DW/8-1:0]   m_sel_i,
  output logic [NUM_M-1:0]        m_ack_o,
  output logic [NUM_M-1:0]        m_err_o,
  output logic [DW-1:0]           m_dat_o,
  output logic                    s_cyc_o,
  output logic                    s_stb_o,
  output logic                    s_we_o,
  output logic [AW-1:0]           s_adr_o,
  output logic [DW-1:0]           s_dat_o,
  output logic [DW/8-1:0]         s_sel_o,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic [DW-1:0]           s_dat_i,
  output logic [NUM_M-1:0]        grant_o
);

  localparam int unsigned IW = (NUM_M > 2) ? 2 : 1;
  localparam int unsigned SW = DW / 8;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [IW-1:0]    last_q, last_d;

  logic [NUM_M-1:0] req;
  logic [IW-1:0]    own_idx;
  logic             timeout;
  logic             found;
  int               idx;
  logic [NUM_M-1:0] pick_oh;

  // Slave-side mux. AND-OR on the one-hot grant, so an idle arbiter drives zeros.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    own_idx = '0;
    for (int k = 0; k < NUM_M; k++) begin
      s_cyc_o |= grant_q[k] & m_cyc_i[k];
      s_stb_o |= grant_q[k] & m_stb_i[k];
      s_we_o  |= grant_q[k] & m_we_i[k];
      s_adr_o |= {AW{grant_q[k]}} & m_adr_i[k*AW +: AW];
      s_dat_o |= {DW{grant_q[k]}} & m_dat_i[k*DW +: DW];
      s_sel_o |= {SW{grant_q[k]}} & m_sel_i[k*SW +: SW];
      if (grant_q[k]) own_idx = IW'(k);
    end
  end

  assign m_ack_o = grant_q & {NUM_M{s_ack_i}};
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_q;

`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0]       wd_q, wd_d;
  logic [NUM_M-1:0] blk_q, blk_d;
  logic             stall;

  always_comb begin
    stall   = (state_q == StBusy) && s_stb_o && !s_ack_i && !s_err_i;
    timeout = stall && (wd_q == 8'(TIMEOUT_CYC - 1));
    wd_d    = '0;
    if (stall && !timeout) wd_d = wd_q + 8'd1;
    // Block bit survives only while the master keeps CYC high.
    blk_d = blk_q & m_cyc_i;
    if (timeout) blk_d = blk_d | (grant_q & m_cyc_i);
  end

  assign req     = m_cyc_i & ~blk_q;
  assign m_err_o = grant_q & {NUM_M{s_err_i | timeout}};
`else
  assign timeout = 1'b0;
  assign req     = m_cyc_i;
  assign m_err_o = grant_q & {NUM_M{s_err_i}};
`endif

  // Next-state: rotate the search start past the last owner.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    found   = 1'b0;
    idx     = 0;
    pick_oh = '0;
    case (state_q)
      StIdle: begin
        for (int i = 1; i <= NUM_M; i++) begin
          idx = int'(last_q) + i;
          if (idx >= int'(NUM_M)) idx = idx - int'(NUM_M);
          if (!found && req[idx[IW-1:0]]) begin
            found   = 1'b1;
            pick_oh = NUM_M'(1) << idx;
          end
        end
        if (found) begin
          grant_d = pick_oh;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // Release always passes through idle; there are no back-to-back grants.
        if (!s_cyc_o || timeout) begin
          grant_d = '0;
          last_d  = own_idx;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IW'(NUM_M - 1);
`ifdef WB_ARB_TIMEOUT_EN
      wd_q    <= '0;
      blk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
      blk_q   <= blk_d;
`endif
    end
  end

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!nrst) $onehot0(grant_q));
  a_params_ok: assert property (@(posedge clk)
    (NUM_M >= 2) && (NUM_M <= 4) && (TIMEOUT_CYC >= 1) && (TIMEOUT_CYC <= 255));

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter with NUM_M=2. The slave side is driven by the stimulus
// sequence. Each slave ACK pushes its expected owner/address/data onto a scoreboard, and a
// negedge monitor pops and compares it.
module tb_wb_rr_arbiter;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TO = 8;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic [1:0]  m_cyc, m_stb, m_we;
  logic [63:0] m_adr, m_dat;
  logic [7:0]  m_sel;
  logic [1:0]  m_ack, m_err, grant;
  logic [31:0] m_dat_o;
  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_dat_o, s_dat_i;
  logic [3:0]  s_sel;
  logic        s_ack, s_err;

  typedef struct {
    logic [1:0]  ack;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.NUM_M(2), .AW(32), .DW(32), .TIMEOUT_CYC(TO)) dut (
    .clk     (clk),
    .nrst    (nrst),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_we_i  (m_we),
    .m_adr_i (m_adr),
    .m_dat_i (m_dat),
    .m_sel_i (m_sel),
    .m_ack_o (m_ack),
    .m_err_o (m_err),
    .m_dat_o (m_dat_o),
    .s_cyc_o (s_cyc),
    .s_stb_o (s_stb),
    .s_we_o  (s_we),
    .s_adr_o (s_adr),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel),
    .s_ack_i (s_ack),
    .s_err_i (s_err),
    .s_dat_i (s_dat_i),
    .grant_o (grant)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic slave_ack(input logic [1:0] a, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat);
    exp_t e;
    e.ack = a;
    e.we  = we;
    e.adr = adr;
    e.dat = dat;
    sb.push_back(e);
    if (!we) s_dat_i = dat;
    s_ack = 1'b1;
  endtask

  // Scoreboard consumer: every ACK seen by a master must match the oldest expectation.
  always @(negedge clk) begin
    if (nrst === 1'b1 && m_ack !== 2'b00) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 64'(m_ack), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_ack", 64'(m_ack), 64'(e.ack));
        check("sb_adr", 64'(s_adr), 64'(e.adr));
        check("sb_we", 64'(s_we), 64'(e.we));
        if (e.we) check("sb_wdat", 64'(s_dat_o), 64'(e.dat));
        else      check("sb_rdat", 64'(m_dat_o), 64'(e.dat));
      end
    end
  end

  initial begin
    nrst    = 1'b0;
    m_cyc   = 2'b11;
    m_stb   = 2'b11;
    m_we    = 2'b00;
    m_adr   = {32'h0000_0200, 32'h0000_0100};
    m_dat   = '0;
    m_sel   = 8'hFF;
    s_ack   = 1'b0;
    s_err   = 1'b0;
    s_dat_i = '0;

    // Reset held with both masters requesting.
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_grant", 64'(grant), 64'd0);
      check("rst_s_cyc", 64'(s_cyc), 64'd0);
      check("rst_m_ack", 64'(m_ack), 64'd0);
    end

    // Contention from reset: 01,00,10,00,01.
    nrst = 1'b1;
    #1 check("arb_latency_idle", 64'(s_cyc), 64'd0);
    step();
    check("rr_g0", 64'(grant), 64'h1);
    check("rr_adr_m0", 64'(s_adr), 64'h100);
    slave_ack(2'b01, 1'b0, 32'h100, 32'hA5A5_0001);
    m_cyc = 2'b10;
    m_stb = 2'b10;
    #1;
    check("ack_on_drop", 64'(m_ack), 64'h1);
    check("s_cyc_falls", 64'(s_cyc), 64'd0);
    step();
    s_ack = 1'b0;
    check("rr_g1_idle", 64'(grant), 64'd0);
    m_cyc = 2'b11;
    m_stb = 2'b11;
    step();
    check("rr_g2", 64'(grant), 64'h2);
    check("rr_adr_m1", 64'(s_adr), 64'h200);
    slave_ack(2'b10, 1'b0, 32'h200, 32'hA5A5_0002);
    m_cyc = 2'b01;
    m_stb = 2'b01;
    step();
    s_ack = 1'b0;
    check("rr_g3_idle", 64'(grant), 64'd0);
    step();
    check("rr_g4", 64'(grant), 64'h1);
    m_cyc = 2'b00;
    m_stb = 2'b00;
    step();
    check("rr_release", 64'(grant), 64'd0);

    // Single write from M0, slave acks two cycles after the grant.
    m_cyc       = 2'b01;
    m_stb       = 2'b01;
    m_we        = 2'b01;
    m_adr[31:0] = 32'h3000_0010;
    m_dat[31:0] = 32'hDEAD_BEEF;
    m_sel[3:0]  = 4'hF;
    #1 check("wr_latency", 64'(s_cyc), 64'd0);
    step();
    check("wr_grant", 64'(grant), 64'h1);
    check("wr_s_cyc", 64'(s_cyc), 64'h1);
    check("wr_s_adr", 64'(s_adr), 64'h3000_0010);
    check("wr_s_dat", 64'(s_dat_o), 64'hDEAD_BEEF);
    check("wr_s_sel", 64'(s_sel), 64'hF);
    check("wr_s_we", 64'(s_we), 64'h1);
    step();
    check("wr_no_early_ack", 64'(m_ack), 64'd0);
    slave_ack(2'b01, 1'b1, 32'h3000_0010, 32'hDEAD_BEEF);
    step();
    s_ack = 1'b0;
    m_cyc = 2'b00;
    m_stb = 2'b00;
    m_we  = 2'b00;
    #1;
    check("wr_drop_s_cyc", 64'(s_cyc), 64'd0);
    check("wr_grant_held", 64'(grant), 64'h1);
    step();
    check("wr_grant_off", 64'(grant), 64'd0);

    // Read isolation: M1 owns, M0 requests meanwhile.
    m_cyc         = 2'b10;
    m_stb         = 2'b10;
    m_adr[63:32]  = 32'h3000_0004;
    step();
    check("rd_grant", 64'(grant), 64'h2);
    m_cyc = 2'b11;
    m_stb = 2'b11;
    #1;
    check("rd_adr_isolated", 64'(s_adr), 64'h3000_0004);
    check("rd_no_ack", 64'(m_ack), 64'd0);
    step();
    slave_ack(2'b10, 1'b0, 32'h3000_0004, 32'h1234_5678);
    #1;
    check("rd_ack_m1", 64'(m_ack), 64'h2);
    check("rd_dat", 64'(m_dat_o), 64'h1234_5678);
    step();
    s_ack = 1'b0;
    m_cyc = 2'b01;
    m_stb = 2'b01;
    #1;
    check("rd_release_s_cyc", 64'(s_cyc), 64'd0);
    check("rd_m0_no_ack", 64'(m_ack), 64'd0);
    step();
    check("rd_idle_gap", 64'(grant), 64'd0);
    step();
    check("rd_m0_granted", 64'(grant), 64'h1);
    check("rd_m0_adr", 64'(s_adr), 64'h3000_0010);
    m_cyc = 2'b00;
    m_stb = 2'b00;
    step();

    // Locked burst: M0 holds CYC for 4 beats, M1 requests after beat 1.
    m_cyc = 2'b01;
    m_stb = 2'b01;
    m_we  = 2'b01;
    step();
    check("burst_grant", 64'(grant), 64'h1);
    for (int b = 0; b < 4; b++) begin
      m_adr[31:0] = 32'h3000_0100 + 32'(4 * b);
      m_dat[31:0] = 32'hC0DE_0000 + 32'(b);
      slave_ack(2'b01, 1'b1, m_adr[31:0], m_dat[31:0]);
      step();
      s_ack = 1'b0;
      if (b == 0) begin
        m_cyc = 2'b11;
        m_stb = 2'b11;
      end
      check("burst_hold", 64'(grant), 64'h1);
    end
    m_cyc = 2'b10;
    m_stb = 2'b10;
    m_we  = 2'b00;
    #1 check("burst_drop_s_cyc", 64'(s_cyc), 64'd0);
    step();
    check("burst_idle_gap", 64'(grant), 64'd0);
    check("burst_idle_s_cyc", 64'(s_cyc), 64'd0);
    step();
    check("burst_m1_grant", 64'(grant), 64'h2);
    check("burst_m1_adr", 64'(s_adr), 64'h3000_0004);
    m_cyc = 2'b00;
    m_stb = 2'b00;
    step();

    // Reset mid-transfer aborts ownership on that edge.
    m_cyc = 2'b01;
    m_stb = 2'b01;
    step();
    check("abort_pre_grant", 64'(grant), 64'h1);
    nrst = 1'b0;
    step();
    check("abort_grant", 64'(grant), 64'd0);
    check("abort_s_cyc", 64'(s_cyc), 64'd0);
    nrst  = 1'b1;
    m_cyc = 2'b00;
    m_stb = 2'b00;
    step();

`ifdef WB_ARB_TIMEOUT_EN
    // Hung slave: M0 is errored at busy cycle TO, M1 then takes over, and M0 stays blocked.
    m_cyc = 2'b01;
    m_stb = 2'b01;
    step();
    check("to_grant", 64'(grant), 64'h1);
    m_cyc = 2'b11;
    m_stb = 2'b11;
    for (int c = 1; c <= int'(TO); c++) begin
      #1 check("to_err", 64'(m_err), (c == int'(TO)) ? 64'h1 : 64'h0);
      step();
    end
    check("to_release", 64'(grant), 64'd0);
    check("to_s_cyc", 64'(s_cyc), 64'd0);
    step();
    check("to_m1_grant", 64'(grant), 64'h2);
    m_cyc = 2'b01;
    m_stb = 2'b01;
    step();
    check("to_m1_release", 64'(grant), 64'd0);
    step();
    check("to_m0_blocked", 64'(grant), 64'd0);
    m_cyc = 2'b00;
    m_stb = 2'b00;
    step();
    m_cyc = 2'b01;
    m_stb = 2'b01;
    step();
    check("to_m0_regrant", 64'(grant), 64'h1);
    m_cyc = 2'b00;
    m_stb = 2'b00;
    step();
`endif

    step();
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
